// File: rtl/conv_pkg.sv
// Shared helpers for the convolution datapath: width arithmetic and the
// round-half-up / saturate step applied to accumulator results.
package conv_pkg;

    localparam int SAT_IN_W  = 64;
    localparam int SAT_OUT_W = 32;

    typedef struct packed {
        logic signed [SAT_OUT_W-1:0] value;
        logic                        sat;
    } sat_res_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    function automatic int acc_width(input int din_w, input int kern_w, input int ksize, input int nch);
        return din_w + kern_w + clog2(ksize) + clog2(nch) + 1;
    endfunction

    // Callers sign-extend into SAT_IN_W and keep the low out_w bits of value.
    function automatic sat_res_t sat_round(input logic signed [SAT_IN_W-1:0] acc,
                                           input int shift, input int out_w);
        logic signed [SAT_IN_W:0] one, t, hi, lo;
        sat_res_t res;
        one    = '0;
        one[0] = 1'b1;
        t      = {acc[SAT_IN_W-1], acc};
        if (shift > 0) t = t + (one <<< (shift - 1));
        t  = t >>> shift;
        hi = (one <<< (out_w - 1)) - one;
        lo = -hi - one;
        res.sat   = (t > hi) || (t < lo);
        res.value = (t > hi) ? hi[SAT_OUT_W-1:0] :
                    (t < lo) ? lo[SAT_OUT_W-1:0] : t[SAT_OUT_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Registered pairwise reduction of N signed values with a global enable, a
// flushable valid pipe and a sideband tag travelling alongside the valid.
module conv_adder_tree
    import conv_pkg::*;
#(
    parameter  int IN_W  = 24,
    parameter  int N     = 9,
    parameter  int TAG_W = 1,
    localparam int S     = clog2(N),
    localparam int OUT_W = IN_W + S
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    in_vld,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic [N-1:0][IN_W-1:0]  din,
    output logic                    out_vld,
    output logic [TAG_W-1:0]        out_tag,
    output logic signed [OUT_W-1:0] sum
);

    genvar k, i;
    generate
        for (k = 0; k <= S; k++) begin : g_lvl
            localparam int CNT  = (N + (1 << k) - 1) >> k;
            // Node count of the level below, written so k=0 needs no negative shift.
            localparam int PCNT = ((N << 1) + (1 << k) - 2) >> k;
            logic             vld;
            logic [TAG_W-1:0] tag;

            if (k == 0) begin : g_src
                assign vld = in_vld;
                assign tag = in_tag;
            end else begin : g_pipe
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        vld <= 1'b0;
                        tag <= '0;
                    end else if (clr) begin
                        vld <= 1'b0;
                    end else if (en) begin
                        vld <= g_lvl[k-1].vld;
                        tag <= g_lvl[k-1].tag;
                    end
                end
            end

            for (i = 0; i < CNT; i++) begin : g_node
                logic signed [OUT_W-1:0] q;
                if (k == 0) begin : g_in
                    assign q = OUT_W'($signed(din[i]));
                end else if (2 * i + 1 < PCNT) begin : g_add
                    always_ff @(posedge clk or negedge reset_n) begin
                        if (!reset_n)  q <= '0;
                        else if (en)   q <= g_lvl[k-1].g_node[2*i].q + g_lvl[k-1].g_node[2*i+1].q;
                    end
                end else begin : g_pass
                    // Odd leftover element rides through registered to keep alignment.
                    always_ff @(posedge clk or negedge reset_n) begin
                        if (!reset_n)  q <= '0;
                        else if (en)   q <= g_lvl[k-1].g_node[2*i].q;
                    end
                end
            end
        end
    endgenerate

    assign out_vld = g_lvl[S].vld;
    assign out_tag = g_lvl[S].tag;
    assign sum     = g_lvl[S].g_node[0].q;

endmodule

// File: rtl/conv_kernel_mc.sv
// Multi-channel dot-product convolver: per-beat products, adder tree,
// bias-seeded accumulation over NUM_CH beats, then round/saturate.
// Handshake: a beat moves on din_vld && din_rdy, a result on dout_vld && dout_rdy;
// din_rdy drops whenever an unaccepted result stalls the pipe or clear is high.
module conv_kernel_mc
    import conv_pkg::*;
#(
    parameter int KERN_WIDTH = 16,
    parameter int DIN_WIDTH  = 8,
    parameter int DOUT_WIDTH = 8,
    parameter int KERN_SIZE  = 9,
    parameter int NUM_CH     = 4,
    parameter int OUT_SHIFT  = 15
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                clear,
    input  logic [KERN_SIZE-1:0][KERN_WIDTH-1:0] kernel,
    input  logic signed [KERN_WIDTH-1:0]        bias,
    input  logic                                din_vld,
    output logic                                din_rdy,
    input  logic [KERN_SIZE-1:0][DIN_WIDTH-1:0] din,
    output logic                                dout_vld,
    input  logic                                dout_rdy,
    output logic signed [DOUT_WIDTH-1:0]        dout,
    output logic                                dout_sat
);

    localparam int PROD_W = DIN_WIDTH + KERN_WIDTH;
    localparam int S      = clog2(KERN_SIZE);
    localparam int TREE_W = PROD_W + S;
    localparam int ACC_W  = acc_width(DIN_WIDTH, KERN_WIDTH, KERN_SIZE, NUM_CH);
    localparam int CH_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic                              stall, en, accept;
    logic [CH_W-1:0]                   ch_cnt;
    logic                              p_vld;
    logic [CH_W-1:0]                   p_ch;
    logic [KERN_SIZE-1:0][PROD_W-1:0]  prod_q;
    logic                              t_vld;
    logic [CH_W-1:0]                   t_ch;
    logic signed [TREE_W-1:0]          t_sum;
    logic signed [ACC_W-1:0]           acc;
    logic                              a_vld;
    sat_res_t                          rnd;
    logic                              unused_rnd;

    assign stall   = dout_vld && !dout_rdy;
    assign en      = !stall;
    assign din_rdy = !stall && !clear;
    assign accept  = din_vld && din_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      ch_cnt <= '0;
        else if (clear)    ch_cnt <= '0;
        else if (accept)   ch_cnt <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + CH_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_vld  <= 1'b0;
            p_ch   <= '0;
            prod_q <= '0;
        end else if (clear) begin
            p_vld <= 1'b0;
        end else if (en) begin
            p_vld <= accept;
            p_ch  <= ch_cnt;
            for (int i = 0; i < KERN_SIZE; i++)
                prod_q[i] <= PROD_W'($signed(din[i])) * PROD_W'($signed(kernel[i]));
        end
    end

    conv_adder_tree #(
        .IN_W  (PROD_W),
        .N     (KERN_SIZE),
        .TAG_W (CH_W)
    ) u_tree (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (clear),
        .in_vld  (p_vld),
        .in_tag  (p_ch),
        .din     (prod_q),
        .out_vld (t_vld),
        .out_tag (t_ch),
        .sum     (t_sum)
    );

    // Channel 0 reseeds the sum with the bias, dropping any previous group.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            a_vld <= 1'b0;
        end else if (clear) begin
            acc   <= '0;
            a_vld <= 1'b0;
        end else if (en) begin
            a_vld <= t_vld && (t_ch == LAST_CH);
            if (t_vld) acc <= ((t_ch == '0) ? ACC_W'(bias) : acc) + ACC_W'(t_sum);
        end
    end

    assign rnd        = sat_round(SAT_IN_W'(acc), OUT_SHIFT, DOUT_WIDTH);
    assign unused_rnd = ^rnd.value;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_vld <= 1'b0;
            dout     <= '0;
            dout_sat <= 1'b0;
        end else if (clear) begin
            dout_vld <= 1'b0;
        end else if (en) begin
            dout_vld <= a_vld;
            if (a_vld) begin
                dout     <= rnd.value[DOUT_WIDTH-1:0];
                dout_sat <= rnd.sat;
            end
        end
    end

endmodule

// File: tb/tb_conv_kernel_mc.sv
// Directed bench: a 3-tap single-channel instance for arithmetic and latency,
// a 9-tap 4-channel instance for grouping, backpressure, clear and reset.
module tb_conv_kernel_mc;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Instance A: KERN_SIZE=3, NUM_CH=1
    logic                    clear_a, din_vld_a, din_rdy_a, dout_vld_a, dout_rdy_a, dout_sat_a;
    logic [2:0][15:0]        kern_a;
    logic [2:0][7:0]         din_a;
    logic signed [15:0]      bias_a;
    logic signed [7:0]       dout_a;

    // Instance B: KERN_SIZE=9, NUM_CH=4
    logic                    clear_b, din_vld_b, din_rdy_b, dout_vld_b, dout_rdy_b, dout_sat_b;
    logic [8:0][15:0]        kern_b;
    logic [8:0][7:0]         din_b;
    logic signed [15:0]      bias_b;
    logic signed [7:0]       dout_b;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q[$];

    conv_kernel_mc #(.KERN_SIZE(3), .NUM_CH(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear_a), .kernel(kern_a), .bias(bias_a),
        .din_vld(din_vld_a), .din_rdy(din_rdy_a), .din(din_a),
        .dout_vld(dout_vld_a), .dout_rdy(dout_rdy_a), .dout(dout_a), .dout_sat(dout_sat_a)
    );

    conv_kernel_mc #(.KERN_SIZE(9), .NUM_CH(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear_b), .kernel(kern_b), .bias(bias_b),
        .din_vld(din_vld_b), .din_rdy(din_rdy_b), .din(din_b),
        .dout_vld(dout_vld_b), .dout_rdy(dout_rdy_b), .dout(dout_b), .dout_sat(dout_sat_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    // Scoreboard for instance B: every transferred result must match the queue head.
    always @(negedge clk) begin
        logic [8:0] e;
        if (reset_n === 1'b1 && dout_vld_b === 1'b1 && dout_rdy_b === 1'b1) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("b_dout", {23'd0, dout_b, dout_sat_b}, {23'd0, e});
            end else begin
                check("b_spurious_out", 32'(dout_vld_b), 32'd0);
            end
        end
    end

    // Entry and exit aligned to 1 time unit after a rising edge.
    task automatic beat_a(input logic [2:0][7:0] d, input logic [2:0][15:0] k,
                          input int e_dout, input int e_sat, input string tag);
        int lat;
        din_a = d; kern_a = k; din_vld_a = 1'b1;
        @(negedge clk);
        check({tag, "_rdy"}, 32'(din_rdy_a), 32'd1);
        @(posedge clk); #1;
        din_vld_a = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (dout_vld_a === 1'b1) begin lat = n; break; end
        end
        check({tag, "_lat"}, 32'(lat), 32'd5);
        check({tag, "_dout"}, dout_a, e_dout);
        check({tag, "_sat"}, 32'(dout_sat_a), e_sat);
        @(posedge clk); #1;
    endtask

    task automatic send_b(input logic [7:0] d0);
        logic ok;
        din_b = '0; din_b[0] = d0;
        kern_b = {9{16'd16384}};
        din_vld_b = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            ok = din_rdy_b;
            @(posedge clk); #1;
            if (ok) break;
        end
        check("b_accept", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin @(posedge clk); #1; end
    endtask

    task automatic drain_b(input string tag);
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin @(posedge clk); #1; end
        check({tag, "_drain"}, exp_q.size(), 32'd0);
        idle(8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       seen, have_hold;
        logic [8:0] hold;
        reset_n = 1'b0;
        clear_a = 1'b0; din_vld_a = 1'b0; dout_rdy_a = 1'b1; din_a = '0; kern_a = '0; bias_a = '0;
        clear_b = 1'b0; din_vld_b = 1'b0; dout_rdy_b = 1'b1; din_b = '0; kern_b = '0; bias_b = 16'sd32767;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_a_vld", 32'(dout_vld_a), 32'd0);
        check("rst_a_dout", dout_a, 32'd0);
        check("rst_a_sat", 32'(dout_sat_a), 32'd0);
        check("rst_a_rdy", 32'(din_rdy_a), 32'd1);
        check("rst_b_vld", 32'(dout_vld_b), 32'd0);
        check("rst_b_dout", dout_b, 32'd0);
        check("rst_b_sat", 32'(dout_sat_b), 32'd0);
        check("rst_b_rdy", 32'(din_rdy_b), 32'd1);
        @(posedge clk); #1;

        // Basic dot product and latency
        beat_a({3{8'd64}}, {3{16'd16384}}, 96, 0, "t1");
        beat_a({8'd40, 8'hEC, 8'd10}, {16'd8192, 16'd16384, 16'h7FFF}, 10, 0, "t1_mixed");
        // Saturation both ways
        beat_a({3{8'd127}}, {3{16'h7FFF}}, 127, 1, "t2_pos");
        beat_a({3{8'h80}}, {3{16'h7FFF}}, -128, 1, "t2_neg");
        // Rounding around the half-LSB point
        beat_a({8'd0, 8'd0, 8'd1}, {3{16'd16384}}, 1, 0, "t3_half_pos");
        beat_a({8'd0, 8'd0, 8'hFF}, {3{16'd16384}}, 0, 0, "t3_half_neg");
        beat_a({8'd0, 8'd0, 8'd1}, {16'd16384, 16'd16384, 16'd16383}, 0, 0, "t3_below_half");
        beat_a({8'd0, 8'd0, 8'hFF}, {16'd16384, 16'd16384, 16'd16385}, -1, 0, "t3_neg_below");

        // Four-channel groups, bias re-seeded on the second group
        exp_q.push_back({8'(65), 1'b0});
        exp_q.push_back({8'(-63), 1'b0});
        repeat (4) send_b(8'd32);
        repeat (4) send_b(8'hE0);
        din_vld_b = 1'b0;
        drain_b("t4");

        // Backpressure while beats keep arriving
        exp_q.push_back({8'(65), 1'b0});
        exp_q.push_back({8'(-63), 1'b0});
        exp_q.push_back({8'(127), 1'b1});
        fork
            begin
                repeat (4) send_b(8'd32);
                repeat (4) send_b(8'hE0);
                repeat (4) send_b(8'd100);
                din_vld_b = 1'b0;
            end
            begin
                seen = 1'b0;
                for (int n = 0; n < 60; n++) begin
                    @(negedge clk);
                    if (dout_vld_b === 1'b1) begin seen = 1'b1; break; end
                end
                check("t5_first_out", 32'(seen), 32'd1);
                @(posedge clk); #1;
                dout_rdy_b = 1'b0;
                have_hold = 1'b0;
                hold = '0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    if (dout_vld_b === 1'b1) begin
                        check("t5_rdy_stalled", 32'(din_rdy_b), 32'd0);
                        if (!have_hold) begin
                            hold = {dout_b, dout_sat_b};
                            have_hold = 1'b1;
                        end else begin
                            check("t5_hold", {23'd0, dout_b, dout_sat_b}, {23'd0, hold});
                        end
                    end
                    @(posedge clk); #1;
                end
                check("t5_stall_seen", 32'(have_hold), 32'd1);
                dout_rdy_b = 1'b1;
            end
        join
        drain_b("t5");

        // clear after two of four channel beats
        send_b(8'd32);
        send_b(8'd32);
        clear_b = 1'b1;
        @(negedge clk);
        check("t6_clear_rdy", 32'(din_rdy_b), 32'd0);
        @(posedge clk); #1;
        clear_b = 1'b0;
        din_vld_b = 1'b0;
        idle(10);
        exp_q.push_back({8'(-63), 1'b0});
        repeat (4) send_b(8'hE0);
        din_vld_b = 1'b0;
        drain_b("t6_clear");

        // reset after two of four channel beats
        send_b(8'd32);
        send_b(8'd32);
        din_vld_b = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check("t6_rst_vld", 32'(dout_vld_b), 32'd0);
        check("t6_rst_rdy", 32'(din_rdy_b), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(10);
        exp_q.push_back({8'(65), 1'b0});
        repeat (4) send_b(8'd32);
        din_vld_b = 1'b0;
        drain_b("t6_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
